// File: rtl/blake2_block_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blake2_block_feeder_pkg
// Purpose  : Shared BLAKE2 definitions: feeder state enum, BLAKE2b/BLAKE2s
//            word widths and the 16-word compression block size.
// Revision : 1.0 - initial release
// ============================================================================
package blake2_block_feeder_pkg;

    localparam int C_W_BLAKE2B    = 64;
    localparam int C_W_BLAKE2S    = 32;
    localparam int C_BLOCK_WORDS  = 16;

    // Feeder sequencing: collect words, present the block for one cycle,
    // then hold it until the core reports completion.
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/blake2_block_feeder_byte_mask.sv
`default_nettype none
// ============================================================================
// Module   : blake2_byte_mask
// Purpose  : Converts a valid-byte count into a W-bit lane mask; lane i
//            (bits 8i+7:8i) is all ones when i < i_bytes, otherwise zero.
// Ports    : i_bytes - number of valid low-order bytes (0..NB)
//            o_mask  - per-lane byte mask
// Revision : 1.0 - initial release
// ============================================================================
module blake2_byte_mask #(
    parameter int W  = 64,
    parameter int NB = W / 8
) (
    input  logic [$clog2(NB):0] i_bytes,
    output logic [W-1:0]        o_mask
);

    localparam int BW = $clog2(NB) + 1;

    generate
        for (genvar i = 0; i < NB; i++) begin : g_lane
            assign o_mask[8*i +: 8] = (i_bytes > BW'(i)) ? 8'hFF : 8'h00;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/blake2_block_feeder.sv
`default_nettype none
// ============================================================================
// Module   : blake2_block_feeder
// Purpose  : Packs a little-endian word stream into 16-word BLAKE2 message
//            blocks, zero-pads the final block, tracks the byte counter and
//            the first/last flags, and paces issue against the core.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            s_valid_i/s_ready_o        - input word handshake
//            s_data_i/s_bytes_i/s_last_i- word, valid byte count, end of msg
//            blk_valid_o                - one-cycle block strobe to the core
//            blk_data_o/_first/_last/_ll- block fields, stable until done
//            core_done_i                - core finished the issued block
//            msg_done_o                 - final block of message completed
//            err_o                      - sticky protocol error
// Revision : 1.0 - initial release
// ============================================================================
module blake2_block_feeder
    import blake2_block_feeder_pkg::*;
#(
    parameter int W  = C_W_BLAKE2B,
    parameter int NB = W / 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [W-1:0]               s_data_i,
    input  logic [$clog2(NB):0]        s_bytes_i,
    input  logic                       s_last_i,
    output logic                       blk_valid_o,
    output logic [C_BLOCK_WORDS*W-1:0] blk_data_o,
    output logic                       blk_first_o,
    output logic                       blk_last_o,
    output logic [63:0]                blk_ll_o,
    input  logic                       core_done_i,
    output logic                       msg_done_o,
    output logic                       err_o
);

    localparam int            BW      = $clog2(NB) + 1;
    localparam logic [BW-1:0] C_NB    = BW'(NB);
    localparam logic [1:0]    C_FILL  = 2'(ST_FILL);
    localparam logic [1:0]    C_ISSUE = 2'(ST_ISSUE);
    localparam logic [1:0]    C_WAIT  = 2'(ST_WAIT);

    logic [1:0]  r_state;
    logic [3:0]  r_widx;
    logic [63:0] r_ll;
    logic        r_first_pend;   // next block issued is the first of a message
    logic        r_blk_first;
    logic        r_blk_last;
    logic        r_err;
    logic [W-1:0] r_buf [C_BLOCK_WORDS];

    logic          w_xfer;
    logic          w_close;
    logic          w_empty_ok;
    logic          w_illegal;
    logic [BW-1:0] w_bytes_eff;
    logic [W-1:0]  w_mask;

    assign w_xfer = s_valid_i && (r_state == C_FILL);

    // A zero-byte word is only meaningful as the sole word of an empty message.
    assign w_empty_ok = (r_widx == 4'd0) && s_last_i && r_first_pend;

    assign w_illegal = (s_bytes_i > C_NB)
                    || ((s_bytes_i == '0) && !w_empty_ok)
                    || ((s_bytes_i < C_NB) && !s_last_i);

    // Malformed words are absorbed as full words so the stream stays aligned.
    assign w_bytes_eff = w_illegal ? C_NB : s_bytes_i;

    assign w_close = w_xfer && (s_last_i || (r_widx == 4'd15));

    blake2_byte_mask #(
        .W  (W),
        .NB (NB)
    ) u_byte_mask (
        .i_bytes (w_bytes_eff),
        .o_mask  (w_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= C_FILL;
            r_widx       <= 4'd0;
            r_ll         <= 64'd0;
            r_first_pend <= 1'b1;
            r_blk_first  <= 1'b0;
            r_blk_last   <= 1'b0;
            r_err        <= 1'b0;
            for (int k = 0; k < C_BLOCK_WORDS; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            case (r_state)
                C_FILL: begin
                    if (w_xfer) begin
                        r_ll <= r_ll + 64'(w_bytes_eff);
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end
                        // Write the current word; on the last word also clear
                        // every later slot so the block is zero padded.
                        for (int k = 0; k < C_BLOCK_WORDS; k++) begin
                            if (4'(k) == r_widx) begin
                                r_buf[k] <= s_data_i & w_mask;
                            end else if (s_last_i && (4'(k) > r_widx)) begin
                                r_buf[k] <= '0;
                            end
                        end
                        if (w_close) begin
                            r_widx       <= 4'd0;
                            r_state      <= C_ISSUE;
                            r_blk_first  <= r_first_pend;
                            r_first_pend <= 1'b0;
                            r_blk_last   <= s_last_i;
                        end else begin
                            r_widx <= r_widx + 4'd1;
                        end
                    end
                end
                C_ISSUE: begin
                    r_state <= C_WAIT;
                end
                C_WAIT: begin
                    if (core_done_i) begin
                        r_state <= C_FILL;
                        if (r_blk_last) begin
                            r_ll         <= 64'd0;
                            r_first_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= C_FILL;
                end
            endcase
        end
    end

    assign s_ready_o   = (r_state == C_FILL);
    assign blk_valid_o = (r_state == C_ISSUE);
    assign msg_done_o  = (r_state == C_WAIT) && core_done_i && r_blk_last;
    assign blk_first_o = r_blk_first;
    assign blk_last_o  = r_blk_last;
    assign blk_ll_o    = r_ll;
    assign err_o       = r_err;

    generate
        for (genvar k = 0; k < C_BLOCK_WORDS; k++) begin : g_pack
            assign blk_data_o[W*k +: W] = r_buf[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_blake2_block_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_blake2_block_feeder
// Purpose  : Self-checking bench for blake2_block_feeder (W=64). Messages are
//            split into words by a byte-level reference model that predicts
//            each block image, flags and byte count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blake2_block_feeder;

    localparam int W  = 64;
    localparam int NB = 8;
    localparam int BW = 4;
    localparam int BLK_BITS = 16 * W;

    logic                clk = 1'b0;
    logic                reset;
    logic                s_valid_i;
    logic                s_ready_o;
    logic [W-1:0]        s_data_i;
    logic [BW-1:0]       s_bytes_i;
    logic                s_last_i;
    logic                blk_valid_o;
    logic [BLK_BITS-1:0] blk_data_o;
    logic                blk_first_o;
    logic                blk_last_o;
    logic [63:0]         blk_ll_o;
    logic                core_done_i;
    logic                msg_done_o;
    logic                err_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_blkv = 0;

    always #5 clk = ~clk;

    blake2_block_feeder #(.W(W), .NB(NB)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .s_bytes_i   (s_bytes_i),
        .s_last_i    (s_last_i),
        .blk_valid_o (blk_valid_o),
        .blk_data_o  (blk_data_o),
        .blk_first_o (blk_first_o),
        .blk_last_o  (blk_last_o),
        .blk_ll_o    (blk_ll_o),
        .core_done_i (core_done_i),
        .msg_done_o  (msg_done_o),
        .err_o       (err_o)
    );

    always @(negedge clk) begin
        if (blk_valid_o === 1'b1) n_blkv++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [BLK_BITS-1:0] act,
                            input logic [BLK_BITS-1:0] exp);
        int bad;
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            bad = -1;
            for (int k = 15; k >= 0; k--)
                if (act[W*k +: W] !== exp[W*k +: W]) bad = k;
            $display("FAIL %s word %0d: got %h expected %h", nm, bad,
                     act[W*bad +: W], exp[W*bad +: W]);
        end
    endtask

    // Reset for a few cycles and confirm every output is at its idle value.
    task automatic do_reset();
        reset = 1'b1; s_valid_i = 1'b0; core_done_i = 1'b0;
        s_last_i = 1'b0; s_bytes_i = '0; s_data_i = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", s_ready_o, 1);
        chk("rst_valid", blk_valid_o, 0);
        chk("rst_msgdone", msg_done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_first", blk_first_o, 0);
        chk("rst_last", blk_last_o, 0);
        chk("rst_ll", blk_ll_o, 0);
        chk_data("rst_data", blk_data_o, '0);
        @(posedge clk); #1;
    endtask

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send_word(input logic [W-1:0] d, input int nb, input bit last);
        int t = 0;
        s_valid_i = 1'b1; s_data_i = d; s_bytes_i = BW'(nb); s_last_i = last;
        @(negedge clk);
        while (!s_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready_o) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: ready stayed %0b expected 1", s_ready_o);
        end
        @(posedge clk); #1;
        s_valid_i = 1'b0;
    endtask

    // From the ISSUE-cycle sample point: hold in WAIT, then complete the block.
    task automatic finish_block(input bit last, input logic [63:0] ll);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("wait_ready", s_ready_o, 0);
            chk("wait_valid", blk_valid_o, 0);
            chk("wait_ll", blk_ll_o, ll);
            @(posedge clk); #1;
        end
        core_done_i = 1'b1;
        @(negedge clk);
        chk("done_msgdone", msg_done_o, 64'(last));
        chk("done_ready", s_ready_o, 0);
        @(posedge clk); #1;
        core_done_i = 1'b0;
        @(negedge clk);
        chk("after_done_ready", s_ready_o, 1);
        chk("after_done_msgdone", msg_done_o, 0);
        @(posedge clk); #1;
    endtask

    // Byte-level reference: cut the message into NB-byte words, 16 words per
    // block; the expected block image is the message bytes placed at their
    // offset within the block, zero everywhere else.
    task automatic run_msg(input int len, output int nblk_obs, output logic [63:0] ll_obs);
        byte unsigned msg[$];
        int pos, wi, nb, blk0;
        bit last, closed, first;
        logic [63:0] ll;
        logic [BLK_BITS-1:0] expv;
        logic [W-1:0] d;
        blk0 = n_blkv;
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
        pos = 0; ll = 0; first = 1'b1; last = 1'b0; ll_obs = '1;
        while (!last) begin
            expv = '0; wi = 0; closed = 1'b0;
            while (!closed) begin
                nb = (len - pos >= NB) ? NB : len - pos;
                last = (pos + nb == len);
                d = {$urandom, $urandom};   // lanes beyond nb carry junk
                for (int j = 0; j < nb; j++) begin
                    d[8*j +: 8] = msg[pos + j];
                    expv[8*(wi*NB + j) +: 8] = msg[pos + j];
                end
                send_word(d, nb, last);
                pos += nb;
                ll += 64'(nb);
                closed = last || (wi == 15);
                wi++;
            end
            @(negedge clk);
            chk("issue_valid", blk_valid_o, 1);
            chk("issue_first", blk_first_o, 64'(first));
            chk("issue_last", blk_last_o, 64'(last));
            chk("issue_ll", blk_ll_o, ll);
            chk_data("issue_data", blk_data_o, expv);
            if (last) ll_obs = blk_ll_o;
            first = 1'b0;
            finish_block(last, ll);
        end
        repeat (4) @(posedge clk);
        #1;
        nblk_obs = n_blkv - blk0;
    endtask

    typedef struct {
        int          len;
        int          exp_blocks;
        logic [63:0] exp_ll;
    } vec_t;

    initial begin
        vec_t tbl[9];
        int nblk, nx, t, len;
        logic [63:0] llo;

        tbl[0] = '{19, 1, 64'd19};
        tbl[1] = '{128, 1, 64'd128};
        tbl[2] = '{129, 2, 64'd129};
        tbl[3] = '{0, 1, 64'd0};
        tbl[4] = '{64, 1, 64'd64};
        tbl[5] = '{8, 1, 64'd8};
        tbl[6] = '{1, 1, 64'd1};
        tbl[7] = '{256, 2, 64'd256};
        tbl[8] = '{255, 2, 64'd255};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            run_msg(tbl[i].len, nblk, llo);
            chk($sformatf("tbl%0d_blocks", i), 64'(nblk), 64'(tbl[i].exp_blocks));
            chk($sformatf("tbl%0d_ll", i), llo, tbl[i].exp_ll);
            chk($sformatf("tbl%0d_err", i), err_o, 0);
        end

        for (int i = 0; i < 4; i++) begin
            len = $urandom_range(0, 300);
            run_msg(len, nblk, llo);
            chk("rnd_blocks", 64'(nblk), 64'((len == 0) ? 1 : (len + 127) / 128));
            chk("rnd_ll", llo, 64'(len));
            chk("rnd_err", err_o, 0);
        end

        // Backpressure: valid held high through ISSUE and WAIT.
        s_valid_i = 1'b1; s_bytes_i = BW'(NB); s_last_i = 1'b0;
        nx = 0; t = 0;
        while (nx < 16 && t < 100) begin
            s_data_i = {$urandom, $urandom};
            @(negedge clk);
            if (s_ready_o) nx++;
            @(posedge clk); #1;
            t++;
        end
        chk("bp_xfers", 64'(nx), 16);
        @(negedge clk);
        chk("bp_valid", blk_valid_o, 1);
        chk("bp_ready_issue", s_ready_o, 0);
        chk("bp_first", blk_first_o, 1);
        chk("bp_last", blk_last_o, 0);
        chk("bp_ll", blk_ll_o, 128);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_ready_wait", s_ready_o, 0);
        end
        @(posedge clk); #1;
        core_done_i = 1'b1;
        @(negedge clk);
        chk("bp_ready_done", s_ready_o, 0);
        chk("bp_msgdone", msg_done_o, 0);
        @(posedge clk); #1;
        core_done_i = 1'b0;
        @(negedge clk);
        chk("bp_ready_back", s_ready_o, 1);
        @(posedge clk); #1;                 // held word lands as word 0
        send_word({$urandom, $urandom}, 4, 1'b0);   // short non-last word
        @(negedge clk);
        chk("illegal_err", err_o, 1);
        @(posedge clk); #1;
        send_word({$urandom, $urandom}, NB, 1'b1);
        @(negedge clk);
        chk("bp2_valid", blk_valid_o, 1);
        chk("bp2_first", blk_first_o, 0);
        chk("bp2_last", blk_last_o, 1);
        chk("bp2_ll", blk_ll_o, 64'd152);
        finish_block(1'b1, 64'd152);
        chk("err_sticky", err_o, 1);

        // Reset while a 7-word block waits on the core.
        for (int i = 0; i < 7; i++) send_word({$urandom, $urandom}, NB, i == 6);
        @(negedge clk);
        chk("rw_issue", blk_valid_o, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_wait_ready", s_ready_o, 0);
        do_reset();
        core_done_i = 1'b1;
        @(negedge clk);
        chk("rw_stale_msgdone", msg_done_o, 0);
        @(posedge clk); #1;
        core_done_i = 1'b0;
        @(negedge clk);
        chk("rw_stale_valid", blk_valid_o, 0);
        chk("rw_stale_ready", s_ready_o, 1);
        @(posedge clk); #1;
        run_msg(19, nblk, llo);
        chk("rw_next_blocks", 64'(nblk), 1);
        chk("rw_next_ll", llo, 64'd19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
